iob_merge_arb: RTL and testbench



---
 rtl/iob_merge_arb.sv | 152 +++++++++++++++
 tb/tb_iob_merge_arb.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_merge_arb.sv
// -----------------------------------------------------------------------------
// iob_merge_arb
// Arbitrated N-to-1 merger for the IOb native bus. Several masters share one
// slave port; one transaction is outstanding at a time. The winning request is
// latched and forwarded from a register, and the slave response is routed
// combinationally back to the granted master only.
//
// Build option:
//   IOB_MERGE_ARB_RR_EN  defined   -> round-robin arbitration (search starts
//                                     after the last served master)
//                        undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset
//   m_req   N_MASTERS concatenated requests {valid, address, wdata, wstrb},
//           master 0 in the LSBs
//   m_resp  N_MASTERS concatenated responses {rdata, ready}
//   s_req   request to the shared slave
//   s_resp  response from the shared slave {rdata, ready}
// -----------------------------------------------------------------------------
module iob_merge_arb #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  localparam int REQ_W    = 1 + ADDR_W + DATA_W + DATA_W/8,
  localparam int RESP_W   = DATA_W + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS*REQ_W-1:0]    m_req,
  output logic [N_MASTERS*RESP_W-1:0]   m_resp,
  output logic [REQ_W-1:0]              s_req,
  input  logic [RESP_W-1:0]             s_resp
);

  localparam int PTR_W = $clog2(N_MASTERS);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [PTR_W-1:0]     grant;
  logic [REQ_W-1:0]     req_reg;
  logic [N_MASTERS-1:0] m_vld;
  logic                 win_vld;
  logic [PTR_W-1:0]     win_idx;
  logic [REQ_W-1:0]     win_req;
  logic                 s_ready;

  assign s_ready = s_resp[0];

  always_comb begin
    m_vld = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      m_vld[i] = m_req[i*REQ_W + REQ_W - 1];
    end
  end

`ifdef IOB_MERGE_ARB_RR_EN
  logic [PTR_W-1:0] last;

  // Two passes instead of a modulo rotation: first the indices above 'last',
  // then wrap to 0..last. Works for non-power-of-2 master counts.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (!win_vld && m_vld[i] && (i > int'(last))) begin
        win_vld = 1'b1;
        win_idx = PTR_W'(i);
      end
    end
    for (int i = 0; i < N_MASTERS; i++) begin
      if (!win_vld && m_vld[i] && (i <= int'(last))) begin
        win_vld = 1'b1;
        win_idx = PTR_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= PTR_W'(N_MASTERS - 1);
    end else if (state == BUSY && s_ready) begin
      last <= grant;
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (!win_vld && m_vld[i]) begin
        win_vld = 1'b1;
        win_idx = PTR_W'(i);
      end
    end
  end
`endif

  always_comb begin
    win_req = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (PTR_W'(i) == win_idx) begin
        win_req = m_req[i*REQ_W +: REQ_W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = BUSY;
      BUSY:    if (s_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch: the winner's fields are frozen at grant, so later changes
  // on m_req cannot reach s_req (no m_req -> s_req combinational path).
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      req_reg <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && win_vld) begin
        grant   <= win_idx;
        req_reg <= win_req;
      end
    end
  end

  // Latched request always carries valid=1, so it drives s_req unchanged.
  // Slave ready/rdata pass straight through to the granted master only.
  always_comb begin
    s_req  = '0;
    m_resp = '0;
    if (state == BUSY) begin
      s_req = req_reg;
      if (s_ready) begin
        for (int i = 0; i < N_MASTERS; i++) begin
          if (PTR_W'(i) == grant) begin
            m_resp[i*RESP_W +: RESP_W] = s_resp;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_iob_merge_arb.sv
module tb_iob_merge_arb;

  localparam int N      = 3;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int REQ_W  = 1 + AW + DW + DW/8;
  localparam int RESP_W = DW + 1;
  localparam int ALSB   = DW + DW/8;   // LSB of the address field in a request
`ifdef IOB_MERGE_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic                    clk;
  logic                    rst;
  logic [N*REQ_W-1:0]      m_req;
  logic [N*RESP_W-1:0]     m_resp;
  logic [REQ_W-1:0]        s_req;
  logic [RESP_W-1:0]       s_resp;

  // master-side stimulus state
  logic                    mvld   [N];
  logic [AW-1:0]           maddr  [N];
  logic [DW-1:0]           mwdata [N];
  logic [DW/8-1:0]         mwstrb [N];
  bit                      reraise;

  // reference model: transaction-level view of the arbiter
  bit                      mdl_busy;
  int                      mdl_grant;
  int                      mdl_last;
  logic [REQ_W-1:0]        mdl_req;
  int                      served;

  int n_chk;
  int n_err;

  iob_merge_arb #(
    .N_MASTERS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .m_req  (m_req),
    .m_resp (m_resp),
    .s_req  (s_req),
    .s_resp (s_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    m_req = '0;
    for (int i = 0; i < N; i++) begin
      m_req[i*REQ_W +: REQ_W] = {mvld[i], maddr[i], mwdata[i], mwstrb[i]};
    end
  end

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Address bits [9:8] carry the master index so grants are recognisable.
  task automatic new_req(input int m);
    mvld[m]   = 1'b1;
    maddr[m]  = ($urandom & 32'hFFFF_F0FF) | (32'(m) << 8);
    mwdata[m] = $urandom;
    mwstrb[m] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
  endtask

  function automatic int pick();
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = RR_EN ? (mdl_last + 1 + k) % N : k;
      if (mvld[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int sreq_master();
    return int'(s_req[ALSB+8 +: 2]);
  endfunction

  // Compare outputs against the model in the middle of the cycle.
  task automatic check_cycle();
    logic [N*RESP_W-1:0] e_resp;
    @(negedge clk);
    e_resp = '0;
    if (mdl_busy && s_resp[0]) e_resp[mdl_grant*RESP_W +: RESP_W] = s_resp;
    chk("s_req", s_req, mdl_busy ? mdl_req : '0);
    chk("m_resp", m_resp, e_resp);
  endtask

  // Advance the model over the coming edge, then let masters react.
  task automatic tick();
    int w;
    served = -1;
    if (rst) begin
      mdl_busy  = 1'b0;
      mdl_grant = 0;
      mdl_last  = N - 1;
    end else if (!mdl_busy) begin
      w = pick();
      if (w >= 0) begin
        mdl_busy  = 1'b1;
        mdl_grant = w;
        mdl_req   = {mvld[w], maddr[w], mwdata[w], mwstrb[w]};
      end
    end else if (s_resp[0]) begin
      mdl_busy = 1'b0;
      mdl_last = mdl_grant;
      served   = mdl_grant;
    end
    @(posedge clk);
    #1;
    if (served >= 0) begin
      if (reraise) new_req(served);
      else mvld[served] = 1'b0;
    end
  endtask

  task automatic do_reset();
    for (int m = 0; m < N; m++) mvld[m] = 1'b0;
    s_resp = '0;
    rst    = 1'b1;
    check_cycle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int exp_order [6];
    int ng;
    bit prev_v;

    n_chk = 0;
    n_err = 0;
    reraise = 1'b0;
    for (int m = 0; m < N; m++) begin
      mvld[m] = 1'b0; maddr[m] = '0; mwdata[m] = '0; mwstrb[m] = '0;
    end
    s_resp    = '0;
    rst       = 1'b1;
    mdl_busy  = 1'b0;
    mdl_grant = 0;
    mdl_last  = N - 1;
    mdl_req   = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("rst_sreq", s_req, '0);
    chk("rst_mresp", m_resp, '0);

    // single master read, slave answers 3 cycles after s_req
    mvld[0] = 1'b1; maddr[0] = 32'h10; mwdata[0] = '0; mwstrb[0] = '0;
    check_cycle();
    chk("rd_t0_idle", s_req[REQ_W-1], 1'b0);
    tick();
    check_cycle();
    chk("rd_t1_vld", s_req[REQ_W-1], 1'b1);
    chk("rd_t1_addr", s_req[ALSB +: AW], 32'h10);
    tick();
    repeat (2) begin check_cycle(); chk("rd_wait_mresp", m_resp, '0); tick(); end
    s_resp = {32'hCAFEBABE, 1'b1};
    check_cycle();
    chk("rd_t4_m0", m_resp[0 +: RESP_W], {32'hCAFEBABE, 1'b1});
    chk("rd_t4_m1", m_resp[RESP_W +: RESP_W], '0);
    tick();
    s_resp = '0;
    check_cycle();
    chk("rd_t5_idle", s_req, '0);
    tick();

    // write from master 1, zero-wait slave
    do_reset();
    mvld[1] = 1'b1; maddr[1] = 32'h20; mwdata[1] = 32'h12345678; mwstrb[1] = 4'hF;
    check_cycle();
    tick();
    s_resp = {32'h5A5A0001, 1'b1};
    check_cycle();
    chk("wr_sreq", s_req, {1'b1, 32'h20, 32'h12345678, 4'hF});
    chk("wr_m1", m_resp[RESP_W +: RESP_W], {32'h5A5A0001, 1'b1});
    chk("wr_m0", m_resp[0 +: RESP_W], '0);
    tick();
    s_resp = '0;
    check_cycle();
    chk("wr_idle", s_req, '0);
    tick();

    // contention: all masters continuously valid
    do_reset();
    for (int k = 0; k < 6; k++) exp_order[k] = RR_EN ? (k % N) : 0;
    reraise = 1'b1;
    for (int m = 0; m < N; m++) new_req(m);
    ng = 0;
    prev_v = 1'b0;
    for (int c = 0; c < 200 && ng < 6; c++) begin
      s_resp = {32'($urandom), s_req[REQ_W-1] && ($urandom_range(0, 1) == 0)};
      check_cycle();
      if (s_req[REQ_W-1] && !prev_v) begin
        chk($sformatf("order%0d", ng), 128'(sreq_master()), 128'(exp_order[ng]));
        ng++;
      end
      prev_v = s_req[REQ_W-1];
      tick();
    end
    chk("order_count", 128'(ng), 128'(6));
    reraise = 1'b0;

    // wrap-around: serve master 2 alone, then 0 and 2 compete
    do_reset();
    new_req(2);
    check_cycle(); tick();
    s_resp = {32'h0, 1'b1};
    check_cycle();
    chk("wrap_first", 128'(sreq_master()), 128'(2));
    tick();
    s_resp = '0;
    new_req(0); new_req(2);
    check_cycle(); tick();
    check_cycle();
    chk("wrap_next", 128'(sreq_master()), 128'(0));
    tick();

    // reset while busy, late slave ready afterwards
    do_reset();
    new_req(1);
    check_cycle(); tick();
    rst = 1'b1;
    check_cycle();
    chk("rb_busy", 128'(sreq_master()), 128'(1));
    tick();
    rst = 1'b0;
    s_resp = {32'hDEAD0000, 1'b1};
    new_req(0);
    check_cycle();
    chk("rb_sreq", s_req, '0);
    chk("rb_mresp", m_resp, '0);
    tick();
    s_resp = '0;
    check_cycle();
    chk("rb_prio", 128'(sreq_master()), 128'(0));
    tick();

    // request stability after grant
    do_reset();
    mvld[0] = 1'b1; maddr[0] = 32'h44; mwdata[0] = 32'h1; mwstrb[0] = 4'h0;
    check_cycle(); tick();
    maddr[0] = 32'h88;
    check_cycle(); tick();
    check_cycle();
    chk("stab_addr", s_req[ALSB +: AW], 32'h44);
    tick();
    s_resp = {32'h77, 1'b1};
    check_cycle();
    chk("stab_addr_rdy", s_req[ALSB +: AW], 32'h44);
    tick();
    s_resp = '0;

    // randomized traffic with random slave latency and occasional resets
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int m = 0; m < N; m++) begin
        if (!mvld[m] && $urandom_range(0, 9) < 3) new_req(m);
      end
      s_resp = {32'($urandom), ($urandom_range(0, 9) < 4)};
      check_cycle();
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
